// File: rtl/mul_wb_pkg.sv
// Shared types and constants for the multiplier writeback stage.
// Optional feature macro used by this slice: MUL_WB_STICKY_OVF_EN.
package mul_wb_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 2 * DATA_W + 3;

    localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAT  = 2'd1,
        LO   = 2'd2,
        HI   = 2'd3
    } state_t;

endpackage

// File: rtl/mul_sat_fmt.sv
// Combinational formatter: turns the captured product into the beat selected
// by the writeback FSM, with the overflow flag for the chosen format.
module mul_sat_fmt
    import mul_wb_pkg::*;
(
    input  logic [PROD_W-1:0] cap,
    input  state_t            beat,
    output logic [DATA_W-1:0] res_data,
    output logic              flag_ovf
);

    logic sat_fits;
    logic pair_fits;

    // A value fits when every bit above the target sign bit repeats that sign.
    assign sat_fits  = (&cap[PROD_W-1:DATA_W-1])   | ~(|cap[PROD_W-1:DATA_W-1]);
    assign pair_fits = (&cap[PROD_W-1:2*DATA_W-1]) | ~(|cap[PROD_W-1:2*DATA_W-1]);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        res_data = '0;
        flag_ovf = 1'b0;
        case (beat)
            SAT: begin
                if (sat_fits) res_data = cap[DATA_W-1:0];
                else          res_data = cap[PROD_W-1] ? SAT_NEG : SAT_POS;
                flag_ovf = ~sat_fits;
            end
            LO: begin
                res_data = cap[DATA_W-1:0];
                flag_ovf = ~pair_fits;
            end
            HI: begin
                res_data = cap[2*DATA_W-1:DATA_W];
                flag_ovf = ~pair_fits;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_result_wb.sv
// Multiplier writeback: edge-detects completion, captures the product and
// delivers it as one saturated beat or a lo/hi pair. Option: MUL_WB_STICKY_OVF_EN.
module mul_result_wb
    import mul_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] product,
    input  logic              mode_sat,
    input  logic              res_ready,
`ifdef MUL_WB_STICKY_OVF_EN
    input  logic              clr_ovf,
    output logic              ovf_sticky,
`endif
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_last,
    output logic              flag_zero,
    output logic              flag_neg,
    output logic              flag_ovf,
    output logic              busy,
    output logic              err_drop
);

    state_t            state;
    logic [PROD_W-1:0] cap;
    logic              done_q;
    logic              done_evt;
    logic              hs;
    logic              final_hs;
    logic              accept;

    // Everything the consumer sees is derived from state and cap, so it is
    // frozen for as long as a beat is stalled and clears the instant reset hits.
    assign busy      = (state != IDLE);
    assign res_valid = busy;
    assign res_last  = (state == SAT) || (state == HI);
    assign flag_zero = busy & (cap == '0);
    assign flag_neg  = busy & cap[PROD_W-1];

    mul_sat_fmt u_fmt (
        .cap      (cap),
        .beat     (state),
        .res_data (res_data),
        .flag_ovf (flag_ovf)
    );

    assign done_evt = mul_done & ~done_q;
    assign hs       = res_valid & res_ready;
    assign final_hs = hs & res_last;
    // A completion landing on the last handshake is taken, giving bubble-free back-to-back.
    assign accept   = done_evt & (~busy | final_hs);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            cap      <= '0;
            done_q   <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            done_q   <= mul_done;
            err_drop <= done_evt & ~accept;
            if (accept) begin
                cap   <= product;
                state <= mode_sat ? SAT : LO;
            end else if (hs) begin
                case (state)
                    LO:      state <= HI;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MUL_WB_STICKY_OVF_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                  ovf_sticky <= 1'b0;
        else if (final_hs && flag_ovf) ovf_sticky <= 1'b1;
        else if (clr_ovf)            ovf_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_mul_result_wb.sv
// Directed bench for mul_result_wb: vector table plus stall, drop,
// back-to-back and reset sequences.
module tb_mul_result_wb;
    import mul_wb_pkg::*;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              mul_done;
    logic [PROD_W-1:0] product;
    logic              mode_sat;
    logic              res_ready;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              flag_zero;
    logic              flag_neg;
    logic              flag_ovf;
    logic              busy;
    logic              err_drop;
`ifdef MUL_WB_STICKY_OVF_EN
    logic              clr_ovf;
    logic              ovf_sticky;
`endif

    mul_result_wb dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .mul_done   (mul_done),
        .product    (product),
        .mode_sat   (mode_sat),
        .res_ready  (res_ready),
`ifdef MUL_WB_STICKY_OVF_EN
        .clr_ovf    (clr_ovf),
        .ovf_sticky (ovf_sticky),
`endif
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_last   (res_last),
        .flag_zero  (flag_zero),
        .flag_neg   (flag_neg),
        .flag_ovf   (flag_ovf),
        .busy       (busy),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PROD_W-1:0] prod;
        logic              mode;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic              zero;
        logic              neg;
        logic              ovf;
    } vec_t;

    vec_t tbl[11];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string name, input logic [DATA_W-1:0] d, input logic last,
                              input logic z, input logic n, input logic o);
        check({name, ".valid"}, {63'd0, res_valid}, 64'd1);
        check({name, ".data"},  {32'd0, res_data}, {32'd0, d});
        check({name, ".last"},  {63'd0, res_last}, {63'd0, last});
        check({name, ".flags"}, {61'd0, flag_zero, flag_neg, flag_ovf}, {61'd0, z, n, o});
    endtask

    task automatic run_vector(input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        product   = tbl[idx].prod;
        mode_sat  = tbl[idx].mode;
        res_ready = 1'b1;
        mul_done  = 1'b1;
        tick();
        check_beat({nm, ".b0"}, tbl[idx].d0, tbl[idx].mode,
                   tbl[idx].zero, tbl[idx].neg, tbl[idx].ovf);
        if (!tbl[idx].mode) begin
            tick();
            check_beat({nm, ".b1"}, tbl[idx].d1, 1'b1,
                       tbl[idx].zero, tbl[idx].neg, tbl[idx].ovf);
        end
        tick();
        check({nm, ".idle"}, {63'd0, res_valid}, 64'd0);
        mul_done = 1'b0;
        tick();
    endtask

    initial begin
        int cnt;

        tbl[0]  = '{67'h0_0000_0000_0000_7390, 1'b1, 32'h0000_7390, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{67'h0_0000_0100_0000_0000, 1'b1, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{67'h7_FFFF_FF00_0000_0000, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{67'h0,                     1'b1, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{67'h0_0000_0000_7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{67'h0_0000_0000_8000_0000, 1'b1, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{67'h7_FFFF_FFFF_8000_0000, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{67'h0_1234_5678_9ABC_DEF0, 1'b0, 32'h9ABC_DEF0, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{67'h0_8000_0000_0000_0000, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{67'h0,                     1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{67'h7_8000_0000_0000_0000, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

        rst_b     = 1'b0;
        mul_done  = 1'b0;
        product   = '0;
        mode_sat  = 1'b0;
        res_ready = 1'b0;
`ifdef MUL_WB_STICKY_OVF_EN
        clr_ovf   = 1'b0;
`endif
        tick();
        tick();
        check("rst.outs", {28'd0, res_valid, res_data, res_last, flag_zero, flag_neg,
                           flag_ovf, busy, err_drop}, 64'd0);
        rst_b = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_vector(i);

        // Stalled pair: LO beat must hold for three cycles with ready low.
        product   = 67'h7_FFFF_FFFF_FFFF_FFFB;
        mode_sat  = 1'b0;
        res_ready = 1'b0;
        mul_done  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_beat($sformatf("stall.lo%0d", i), 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        res_ready = 1'b1;
        tick();
        check_beat("stall.hi", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("stall.idle", {63'd0, busy}, 64'd0);
        mul_done = 1'b0;
        tick();

        // Second completion while in LO is dropped; original beats survive.
        product   = 67'h0_1111_2222_3333_4444;
        res_ready = 1'b0;
        mul_done  = 1'b1;
        tick();
        mul_done  = 1'b0;
        product   = 67'h0_5555_6666_7777_8888;
        tick();
        mul_done  = 1'b1;
        tick();
        check("drop.pulse", {63'd0, err_drop}, 64'd1);
        tick();
        check("drop.once", {63'd0, err_drop}, 64'd0);
        check_beat("drop.lo", 32'h3333_4444, 1'b0, 1'b0, 1'b0, 1'b0);
        res_ready = 1'b1;
        tick();
        check_beat("drop.hi", 32'h1111_2222, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("drop.idle", {63'd0, res_valid}, 64'd0);
        mul_done = 1'b0;
        tick();

        // Completion coincides with the HI handshake: no gap, then a held level yields one result.
        product   = 67'h0_0000_000A_0000_000B;
        mode_sat  = 1'b0;
        res_ready = 1'b1;
        mul_done  = 1'b1;
        tick();
        check_beat("b2b.lo", 32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b0);
        mul_done = 1'b0;
        tick();
        check_beat("b2b.hi", 32'h0000_000A, 1'b1, 1'b0, 1'b0, 1'b0);
        product  = 67'h0_0000_0000_0000_0123;
        mode_sat = 1'b1;
        mul_done = 1'b1;
        tick();
        check_beat("b2b.sat", 32'h0000_0123, 1'b1, 1'b0, 1'b0, 1'b0);
        check("b2b.nodrop", {63'd0, err_drop}, 64'd0);
        cnt = 1;
        for (int i = 0; i < 19; i++) begin
            mode_sat = ~mode_sat;
            tick();
            if (res_valid) cnt++;
        end
        check("hold.count", cnt, 64'd1);
        mul_done = 1'b0;
        tick();

        // Reset during the HI wait; level still high afterwards gives one result.
        product   = 67'h0_0000_0000_0000_7390;
        mode_sat  = 1'b0;
        res_ready = 1'b1;
        mul_done  = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        check("rst.inhi", {63'd0, res_last}, 64'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("rst.async", {28'd0, res_valid, res_data, res_last, flag_zero, flag_neg,
                            flag_ovf, busy, err_drop}, 64'd0);
        tick();
        mode_sat  = 1'b1;
        res_ready = 1'b1;
        rst_b     = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) begin
                cnt++;
                check("rst.data", {32'd0, res_data}, 64'h7390);
            end
        end
        check("rst.count", cnt, 64'd1);
        mul_done = 1'b0;
        tick();

`ifdef MUL_WB_STICKY_OVF_EN
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("sticky.clr0", {63'd0, ovf_sticky}, 64'd0);
        run_vector(0);
        check("sticky.noset", {63'd0, ovf_sticky}, 64'd0);
        run_vector(1);
        check("sticky.set", {63'd0, ovf_sticky}, 64'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("sticky.clr", {63'd0, ovf_sticky}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
